jtag_instruction_register: RTL and testbench
============================================

// Module: jtag_instruction_register
// PURPOSE
// - N-bit JTAG instruction register with decoder. Sits downstream of the TAP controller's IR strobes.
// - Captures the fixed 1149.1 pattern plus status bits, then shifts TDI->TDO.
// - On update, latches the opcode and drives one-hot data-register selects to the DR mux.
// - Tracks the shift length and flags IR scans that were not exactly IR_WIDTH bits long.
// PARAMETERS
// - IR_WIDTH     4      instruction length in bits, >= 3
// - OP_EXTEST    4'h0   EXTEST opcode (IR_WIDTH bits)
// - OP_SAMPLE    4'h1   SAMPLE/PRELOAD opcode
// - OP_IDCODE    4'h2   IDCODE opcode; also the reset instruction
// - OP_BYPASS    4'hF   BYPASS opcode (all ones)
// PORTS
// - ClockIR    in   1            TCK-rate clock; all state updates on its rising edge
// - Reset      in   1            synchronous, active-high
// - TDI        in   1            serial data in
// - CaptureIR  in   1            Capture-IR state strobe
// - ShiftIR    in   1            Shift-IR state strobe
// - UpdateIR   in   1            Update-IR state strobe (an enable, not a clock)
// - Status     in   IR_WIDTH-2   device status, loaded into shift[IR_WIDTH-1:2] on capture
// - TDO        out  1            shift[0], combinational from the shift register
// - Instr      out  IR_WIDTH     active (updated) instruction
// - SelBypass  out  1            BYPASS DR selected
// - SelIdcode  out  1            IDCODE DR selected
// - SelBscan   out  1            boundary-scan DR selected (EXTEST or SAMPLE)
// - ExtestMode out  1            boundary cells drive pins (EXTEST active)
// - ShortShift out  1            last update followed a scan whose length was != IR_WIDTH
// BEHAVIOUR
// - Registers: shift[IR_WIDTH-1:0], Instr, cnt (saturating at IR_WIDTH+1), ShortShift.
// - Reset (synchronous, active-high, highest priority):
//   - shift <= {Status, 2'b01}; Instr <= OP_IDCODE; cnt <= 0; ShortShift <= 0.
//   - Outputs after reset: SelIdcode=1; SelBypass=0; SelBscan=0; ExtestMode=0.
// - Edge priority when not in reset: CaptureIR > ShiftIR > UpdateIR.
//   - The TAP keeps these strobes mutually exclusive; overlaps still resolve by this priority.
// - Capture: shift <= {Status, 2'b01}; cnt <= 0.
// - Shift: shift <= {TDI, shift[IR_WIDTH-1:1]}; cnt <= min(cnt+1, IR_WIDTH+1).
//   - TDO changes on the same edge. First captured bit (1) appears on TDO before the first shift.
// - Update: Instr <= shift; ShortShift <= (cnt != IR_WIDTH); shift and cnt unchanged.
//   - Selects and ExtestMode follow the update edge with 0 extra cycles (decoded from Instr).
// - No strobe active: all state holds.
// - Decode of Instr (exactly one of SelBypass/SelIdcode/SelBscan is high at all times):
//   - OP_EXTEST -> SelBscan=1, ExtestMode=1
//   - OP_SAMPLE -> SelBscan=1, ExtestMode=0
//   - OP_IDCODE -> SelIdcode=1
//   - OP_BYPASS or any unlisted opcode -> SelBypass=1
// - Reset asserted mid-scan: shift contents are discarded and Instr returns to OP_IDCODE
//   on that edge. No partial update.
// - Update without a preceding shift: latches the captured pattern {Status, 01}.
//   - ShortShift=1, because cnt=0.
// TESTING
// - Reset pulse -> Instr=0x2, SelIdcode=1, ExtestMode=0, TDO=1 (LSB of captured 01).
// - Capture with Status=2'b10, then 4 shifts with TDI=1,1,1,1 ->
//   TDO sequence 1,0,0,1; Update -> Instr=0xF, SelBypass=1, ShortShift=0.
// - Capture, shift in 0x0 (4 bits), Update -> SelBscan=1, ExtestMode=1.
//   Then shift in 0x1, Update -> ExtestMode=0.
// - Capture, 3 shifts, Update -> ShortShift=1; Capture, 6 shifts, Update -> ShortShift=1, cnt saturates at 5.
// - Load opcode 0x7, Update -> SelBypass=1 (unlisted opcode). Assert Reset mid-shift -> Instr=0x2 next edge.
// - CaptureIR and ShiftIR high together -> shift reloads {Status, 01}, cnt=0; no shift occurs.

Source files
------------

// File: rtl/jtag_instruction_register.sv
// JTAG instruction register: captures the 1149.1 "01" pattern plus device status,
// shifts TDI->TDO, latches the opcode on update and decodes one-hot DR selects.
module jtag_instruction_register #(
  parameter int                  IR_WIDTH  = 4,
  parameter logic [IR_WIDTH-1:0] OP_EXTEST = 'h0,
  parameter logic [IR_WIDTH-1:0] OP_SAMPLE = 'h1,
  parameter logic [IR_WIDTH-1:0] OP_IDCODE = 'h2,
  parameter logic [IR_WIDTH-1:0] OP_BYPASS = '1
) (
  input  logic                ClockIR,
  input  logic                Reset,
  input  logic                TDI,
  input  logic                CaptureIR,
  input  logic                ShiftIR,
  input  logic                UpdateIR,
  input  logic [IR_WIDTH-3:0] Status,
  output logic                TDO,
  output logic [IR_WIDTH-1:0] Instr,
  output logic                SelBypass,
  output logic                SelIdcode,
  output logic                SelBscan,
  output logic                ExtestMode,
  output logic                ShortShift
);

  // The counter must reach IR_WIDTH+1 so that over-long scans stick as "not exact".
  localparam int            CW       = $clog2(IR_WIDTH + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(IR_WIDTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(IR_WIDTH + 1);

  logic [IR_WIDTH-1:0] shift;
  logic [CW-1:0]       cnt;

  always_ff @(posedge ClockIR) begin
    if (Reset) begin
      shift      <= {Status, 2'b01};
      Instr      <= OP_IDCODE;
      cnt        <= '0;
      ShortShift <= 1'b0;
    end else if (CaptureIR) begin
      shift <= {Status, 2'b01};
      cnt   <= '0;
    end else if (ShiftIR) begin
      shift <= {TDI, shift[IR_WIDTH-1:1]};
      if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end else if (UpdateIR) begin
      Instr      <= shift;
      ShortShift <= (cnt != CNT_FULL);
    end
  end

  assign TDO = shift[0];

  // BYPASS is the fallback so that exactly one select is always high.
  always_comb begin
    SelBypass  = 1'b0;
    SelIdcode  = 1'b0;
    SelBscan   = 1'b0;
    ExtestMode = 1'b0;
    if (Instr == OP_EXTEST) begin
      SelBscan   = 1'b1;
      ExtestMode = 1'b1;
    end else if (Instr == OP_SAMPLE) begin
      SelBscan = 1'b1;
    end else if (Instr == OP_IDCODE) begin
      SelIdcode = 1'b1;
    end else begin
      SelBypass = 1'b1;
    end
  end

endmodule

// File: tb/tb_jtag_instruction_register.sv
// Self-checking bench for jtag_instruction_register: directed scenarios plus a
// randomized strobe sequence checked against a bit-queue reference model.
module tb_jtag_instruction_register;

  localparam int W = 4;

  logic         ClockIR = 1'b0;
  logic         Reset = 1'b0;
  logic         TDI = 1'b0;
  logic         CaptureIR = 1'b0;
  logic         ShiftIR = 1'b0;
  logic         UpdateIR = 1'b0;
  logic [W-3:0] Status = '0;
  logic         TDO;
  logic [W-1:0] Instr;
  logic         SelBypass, SelIdcode, SelBscan, ExtestMode, ShortShift;

  int checks = 0;
  int errors = 0;

  // Reference model: mq[0] is the bit currently on TDO; mLen is the raw scan length.
  bit           mq[$];
  logic [W-1:0] mInstr;
  bit           mShort;
  int           mLen;

  jtag_instruction_register #(.IR_WIDTH(W)) dut (
    .ClockIR(ClockIR), .Reset(Reset), .TDI(TDI), .CaptureIR(CaptureIR),
    .ShiftIR(ShiftIR), .UpdateIR(UpdateIR), .Status(Status), .TDO(TDO),
    .Instr(Instr), .SelBypass(SelBypass), .SelIdcode(SelIdcode),
    .SelBscan(SelBscan), .ExtestMode(ExtestMode), .ShortShift(ShortShift)
  );

  always #5 ClockIR = ~ClockIR;

  function automatic logic [W-1:0] mValue();
    logic [W-1:0] v = '0;
    for (int i = 0; i < W; i++) v[i] = mq[i];
    return v;
  endfunction

  // {SelBypass, SelIdcode, SelBscan, ExtestMode} expected for an opcode
  function automatic logic [3:0] expSel(input logic [W-1:0] op);
    case (op)
      4'h0:    return 4'b0011;
      4'h1:    return 4'b0010;
      4'h2:    return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  function automatic logic [3:0] dutSel();
    return {SelBypass, SelIdcode, SelBscan, ExtestMode};
  endfunction

  task automatic mCapture();
    mq.delete();
    mq.push_back(1'b1);
    mq.push_back(1'b0);
    for (int i = 0; i < W - 2; i++) mq.push_back(Status[i]);
    mLen = 0;
  endtask

  // One clock with the given strobes; the model applies the priority rules at the edge.
  task automatic step(input bit rst, input bit cap, input bit sh, input bit upd, input bit tdiv);
    Reset = rst; CaptureIR = cap; ShiftIR = sh; UpdateIR = upd; TDI = tdiv;
    @(posedge ClockIR);
    if (rst) begin
      mCapture();
      mInstr = 4'h2;
      mShort = 1'b0;
    end else if (cap) begin
      mCapture();
    end else if (sh) begin
      void'(mq.pop_front());
      mq.push_back(tdiv);
      mLen++;
    end else if (upd) begin
      mInstr = mValue();
      mShort = (mLen != W);
    end
    #1;
    Reset = 1'b0; CaptureIR = 1'b0; ShiftIR = 1'b0; UpdateIR = 1'b0; TDI = 1'b0;
  endtask

  task automatic scanIn(input logic [31:0] value, input int len);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < len; i++) step(0, 0, 1, 0, value[i % 32]);
  endtask

  task automatic test_reset();
    Status = 2'b11;
    step(1, 0, 0, 0, 0);
    checks++; if (Instr !== 4'h2) begin errors++; $display("[TB] FAIL reset_instr got %h want 2", Instr); end
    checks++; if (dutSel() !== 4'b0100) begin errors++; $display("[TB] FAIL reset_sel got %b want 0100", dutSel()); end
    checks++; if (TDO !== 1'b1) begin errors++; $display("[TB] FAIL reset_tdo got %b want 1", TDO); end
    checks++; if (ShortShift !== 1'b0) begin errors++; $display("[TB] FAIL reset_short got %b want 0", ShortShift); end
  endtask

  task automatic test_bypass_scan();
    bit expT[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    Status = 2'b10;
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (TDO !== expT[i]) begin errors++; $display("[TB] FAIL bypass_tdo[%0d] got %b want %b", i, TDO, expT[i]); end
      step(0, 0, 1, 0, 1);
    end
    step(0, 0, 0, 1, 0);
    checks++; if (Instr !== 4'hF) begin errors++; $display("[TB] FAIL bypass_instr got %h want f", Instr); end
    checks++; if (dutSel() !== 4'b1000) begin errors++; $display("[TB] FAIL bypass_sel got %b want 1000", dutSel()); end
    checks++; if (ShortShift !== 1'b0) begin errors++; $display("[TB] FAIL bypass_short got %b want 0", ShortShift); end
  endtask

  task automatic test_extest_sample();
    scanIn(32'h0, 4);
    step(0, 0, 0, 1, 0);
    checks++; if (dutSel() !== 4'b0011) begin errors++; $display("[TB] FAIL extest_sel got %b want 0011", dutSel()); end
    scanIn(32'h1, 4);
    step(0, 0, 0, 1, 0);
    checks++; if (Instr !== 4'h1) begin errors++; $display("[TB] FAIL sample_instr got %h want 1", Instr); end
    checks++; if (dutSel() !== 4'b0010) begin errors++; $display("[TB] FAIL sample_sel got %b want 0010", dutSel()); end
  endtask

  task automatic test_short_scans();
    int lens[5]   = '{3, 6, 12, 20, 4};
    bit shorts[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 5; k++) begin
      scanIn($urandom, lens[k]);
      step(0, 0, 0, 1, 0);
      checks++; if (ShortShift !== shorts[k]) begin errors++; $display("[TB] FAIL short_len%0d got %b want %b", lens[k], ShortShift, shorts[k]); end
      checks++; if (Instr !== mInstr) begin errors++; $display("[TB] FAIL short_instr_len%0d got %h want %h", lens[k], Instr, mInstr); end
    end
  endtask

  task automatic test_unlisted_and_reset();
    scanIn(32'h7, 4);
    step(0, 0, 0, 1, 0);
    checks++; if (Instr !== 4'h7) begin errors++; $display("[TB] FAIL unlisted_instr got %h want 7", Instr); end
    checks++; if (dutSel() !== 4'b1000) begin errors++; $display("[TB] FAIL unlisted_sel got %b want 1000", dutSel()); end
    Status = 2'b01;
    scanIn(32'hC, 2);
    step(1, 0, 1, 0, 1);
    checks++; if (Instr !== 4'h2) begin errors++; $display("[TB] FAIL midreset_instr got %h want 2", Instr); end
    checks++; if (TDO !== 1'b1) begin errors++; $display("[TB] FAIL midreset_tdo got %b want 1", TDO); end
    step(0, 0, 0, 1, 0);
    checks++; if (Instr !== 4'h5) begin errors++; $display("[TB] FAIL noshift_instr got %h want 5", Instr); end
    checks++; if (ShortShift !== 1'b1) begin errors++; $display("[TB] FAIL noshift_short got %b want 1", ShortShift); end
  endtask

  task automatic test_overlap();
    Status = 2'b00;
    scanIn(32'hE, 4);
    step(0, 1, 1, 0, 1);
    checks++; if (TDO !== 1'b1) begin errors++; $display("[TB] FAIL overlap_tdo got %b want 1", TDO); end
    step(0, 1, 0, 1, 0);
    checks++; if (Instr !== 4'h5) begin errors++; $display("[TB] FAIL capupd_instr got %h want 5", Instr); end
    step(0, 0, 1, 1, 1);
    checks++; if (Instr !== 4'h5) begin errors++; $display("[TB] FAIL shupd_instr got %h want 5", Instr); end
    step(0, 0, 0, 1, 0);
    checks++; if (Instr !== 4'h8) begin errors++; $display("[TB] FAIL overlap_update got %h want 8", Instr); end
    checks++; if (ShortShift !== 1'b1) begin errors++; $display("[TB] FAIL overlap_short got %b want 1", ShortShift); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      int pick = $urandom_range(0, 99);
      Status = 2'($urandom);
      step(pick < 3, (pick >= 3 && pick < 15) || pick == 99, pick >= 15 && pick < 75,
           (pick >= 75 && pick < 95) || pick == 98, 1'($urandom));
      checks++; if (TDO !== mq[0]) begin errors++; $display("[TB] FAIL rand_tdo[%0d] got %b want %b", n, TDO, mq[0]); end
      checks++; if (Instr !== mInstr) begin errors++; $display("[TB] FAIL rand_instr[%0d] got %h want %h", n, Instr, mInstr); end
      checks++; if (dutSel() !== expSel(mInstr)) begin errors++; $display("[TB] FAIL rand_sel[%0d] got %b want %b", n, dutSel(), expSel(mInstr)); end
      checks++; if (ShortShift !== mShort) begin errors++; $display("[TB] FAIL rand_short[%0d] got %b want %b", n, ShortShift, mShort); end
    end
  endtask

  initial begin
    test_reset();
    test_bypass_scan();
    test_extest_sample();
    test_short_scans();
    test_unlisted_and_reset();
    test_overlap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
